alu_status: RTL

// - Downstream stage of the 8-bit ALU: registers ALU result, derives N/Z/C/V, holds 6502 status register P.
// - Applies NMOS-style BCD correction in one extra cycle when D=1 and the op requests it.
// - Also serves PLP/RTI loads, SEx/CLx flag instructions, interrupt I-set and the push image of P.

---
 rtl/alu_status.sv | 88 ++++++++
 1 files changed

// File: rtl/alu_status.sv
// alu_status: 6502 ALU result register, N/V/Z/C derivation and status register P.
// Optional NMOS-style BCD correction (one extra ADJ cycle) when ALU_STATUS_DECIMAL_EN is defined.
module alu_status #(
  parameter logic [7:0] RESET_P = 8'h34
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic       alu_ci,
  input  logic [7:0] alu_f,
  input  logic       alu_co,
  input  logic       alu_valid,
  input  logic       sub,
  input  logic       dec_req,
  input  logic [3:0] upd,
  input  logic       load_p,
  input  logic [7:0] db_in,
  input  logic [7:0] set_mask,
  input  logic [7:0] clr_mask,
  input  logic       irq_set_i,
  input  logic       b_push,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic [7:0] p,
  output logic [7:0] p_push
);
  typedef enum logic {IDLE, ADJ} state_t;
  state_t state, state_n;
  logic [7:0] a_q, b_q, f_q, sa, sb, sf, r1, dec_r, res_n, p_alu, p_n;
  logic       ci_q, co_q, sub_q, sci, sco, hc, lo_fix, hi_fix, fin, c_n, v;
  logic [3:0] upd_q, su;
  logic [4:0] lo_sum;
  logic       dec_go;
`ifdef ALU_STATUS_DECIMAL_EN
  assign dec_go = alu_valid & dec_req & p[3];
`else
  logic unused_dec;
  assign unused_dec = dec_req;
  assign dec_go = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb state_n = (state == IDLE && dec_go) ? ADJ : IDLE;
  always_comb begin
    busy = state == ADJ;
    p_push = {p[7:6], 1'b1, b_push, p[3:0]};
  end
  // In ADJ the latched operands drive the flag logic; in IDLE the live ALU outputs do.
  always_comb begin
    sa = busy ? a_q : alu_a;
    sb = busy ? b_q : alu_b;
    sf = busy ? f_q : alu_f;
    sci = busy ? ci_q : alu_ci;
    sco = busy ? co_q : alu_co;
    lo_sum = {1'b0, sa[3:0]} + {1'b0, sb[3:0]} + {4'b0, sci};
    hc = lo_sum[4];
    lo_fix = hc | (sf[3:0] > 4'd9);
    r1 = sf + (lo_fix ? 8'h06 : 8'h00);
    hi_fix = sco | (r1[7:4] > 4'd9);
    dec_r = sub_q ? {sf[7:4] - (sco ? 4'd0 : 4'd6), sf[3:0] - (hc ? 4'd0 : 4'd6)}
                  : r1 + (hi_fix ? 8'h60 : 8'h00);
    fin = busy | (alu_valid & ~dec_go);
    res_n = busy ? dec_r : alu_f;
    c_n = (busy & ~sub_q) ? hi_fix : sco;
    v = (sa[7] == sb[7]) & (sf[7] != sa[7]);
    su = fin ? (busy ? upd_q : upd) : 4'h0;
    p_alu = {su[3] ? sf[7] : p[7], su[2] ? v : p[6], p[5:2], su[1] ? sf == 8'h00 : p[1], su[0] ? c_n : p[0]};
    p_n = (p_alu & ~clr_mask) | set_mask;
    p_n[2] = p_n[2] | irq_set_i;
    p_n = load_p ? db_in : p_n;
    p_n[5:4] = 2'b11;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p <= RESET_P;
      result <= 8'h00;
      result_valid <= 1'b0;
      {a_q, b_q, f_q, ci_q, co_q, sub_q, upd_q} <= '0;
    end else begin
      p <= p_n;
      result_valid <= fin;
      if (fin) result <= res_n;
      if (state == IDLE && dec_go) {a_q, b_q, f_q, ci_q, co_q, sub_q, upd_q} <= {alu_a, alu_b, alu_f, alu_ci, alu_co, sub, upd};
    end
endmodule
